// File: rtl/ac3_pkg.sv
// Shared types and width helper for the AC3 accumulator bank.
// Saturating accumulation is selected with the AC3_SAT_EN macro.
package ac3_pkg;

    localparam int NREG = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int ac3_w(input int m, input int pa,
                                 input int pw, input int mno);
        return $clog2(m) + pa + pw + $clog2(mno);
    endfunction

    localparam int W_DEF = ac3_w(16, 8, 8, 288);

endpackage

// File: rtl/ac3_sat_add.sv
// W-bit unsigned adder with carry-out; saturates to all-ones when
// AC3_SAT_EN is defined, otherwise wraps modulo 2^W.
module ac3_sat_add #(
    parameter int W = 29
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[W];

`ifdef AC3_SAT_EN
    assign sum = carry ? {W{1'b1}} : full[W-1:0];
`else
    assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/ac3_acc_bank.sv
// Four-entry accumulator bank: accumulates NACC words, then drains.
// AC3_SAT_EN selects saturating instead of wrapping accumulation.
module ac3_acc_bank
    import ac3_pkg::*;
#(
    parameter int M    = 16,
    parameter int Pa   = 8,
    parameter int Pw   = 8,
    parameter int MNO  = 288,
    parameter int NACC = 288,
    localparam int W   = ac3_w(M, Pa, Pw, MNO)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_idx,
    output logic         busy,
    output logic         ovf
);

    localparam int CW = $clog2(MNO + 1);
    localparam logic [CW-1:0] LAST = CW'(NACC - 1);

    state_t         state;
    logic [W-1:0]   acc [NREG];
    logic [CW-1:0]  cnt;
    logic [1:0]     idx;
    logic           ovf_q;
    logic [W-1:0]   add_sum;
    logic           add_carry;
    logic           in_hs;
    logic           out_hs;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign ovf       = ovf_q;
    assign out_idx   = idx;
    assign out_data  = out_valid ? acc[idx] : '0;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // One adder serves whichever accumulator in_sel targets.
    ac3_sat_add #(.W(W)) u_add (
        .a     (acc[in_sel]),
        .b     (in_data),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                acc[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        cnt   <= '0;
                        idx   <= '0;
                        ovf_q <= 1'b0;
                        for (int i = 0; i < NREG; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (in_hs) begin
                        acc[in_sel] <= add_sum;
                        cnt         <= cnt + 1'b1;
                        if (add_carry) begin
                            ovf_q <= 1'b1;
                        end
                        if (cnt == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ac3_acc_bank.sv
// Directed bench for ac3_acc_bank: table of NACC=4 runs plus
// hand sequences for stall, reset, gaps, overflow and NACC=1.
module tb_ac3_acc_bank;

    localparam int W = 29;

    typedef struct {
        logic [3:0][W-1:0] d;
        logic [3:0][1:0]   s;
        logic [3:0][W-1:0] e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic         start4 = 0, in_valid4 = 0, out_ready4 = 0;
    logic [W-1:0] in_data4 = '0;
    logic [1:0]   in_sel4 = '0;
    logic         in_ready4, out_valid4, busy4, ovf4;
    logic [W-1:0] out_data4;
    logic [1:0]   out_idx4;

    logic         start2 = 0, in_valid2 = 0, out_ready2 = 0;
    logic [W-1:0] in_data2 = '0;
    logic [1:0]   in_sel2 = '0;
    logic         in_ready2, out_valid2, busy2, ovf2;
    logic [W-1:0] out_data2;
    logic [1:0]   out_idx2;

    logic         start1 = 0, in_valid1 = 0, out_ready1 = 0;
    logic [W-1:0] in_data1 = '0;
    logic [1:0]   in_sel1 = '0;
    logic         in_ready1, out_valid1, busy1, ovf1;
    logic [W-1:0] out_data1;
    logic [1:0]   out_idx1;

    ac3_acc_bank #(.NACC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_sel(in_sel4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_idx(out_idx4),
        .busy(busy4), .ovf(ovf4)
    );

    ac3_acc_bank #(.NACC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_sel(in_sel2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_idx(out_idx2),
        .busy(busy2), .ovf(ovf2)
    );

    ac3_acc_bank #(.NACC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_sel(in_sel1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_idx(out_idx1),
        .busy(busy1), .ovf(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d0, d1, d2, d3,
                                input int s0, s1, s2, s3,
                                input int e0, e1, e2, e3);
        vec_t v;
        v.d[0] = W'(d0); v.d[1] = W'(d1); v.d[2] = W'(d2); v.d[3] = W'(d3);
        v.s[0] = 2'(s0); v.s[1] = 2'(s1); v.s[2] = 2'(s2); v.s[3] = 2'(s3);
        v.e[0] = W'(e0); v.e[1] = W'(e1); v.e[2] = W'(e2); v.e[3] = W'(e3);
        return v;
    endfunction

    // All tasks are entered and left on a falling edge.
    task automatic start4_pulse();
        start4 = 1;
        @(negedge clk);
        start4 = 0;
    endtask

    task automatic feed4(input logic [W-1:0] d, input logic [1:0] s);
        in_valid4 = 1;
        in_data4  = d;
        in_sel4   = s;
        @(negedge clk);
        in_valid4 = 0;
    endtask

    task automatic drain4(input logic [3:0][W-1:0] e, input int from);
        out_ready4 = 1;
        for (int k = from; k < 4; k++) begin
            check("drain_valid", 32'(out_valid4), 32'd1);
            check("drain_idx", 32'(out_idx4), 32'(k));
            check("drain_data", 32'(out_data4), 32'(e[k]));
            @(negedge clk);
        end
        out_ready4 = 0;
        check("busy_after_drain", 32'(busy4), 32'd0);
        check("out_valid_after_drain", 32'(out_valid4), 32'd0);
    endtask

    vec_t vecs [4];
    vec_t v;
    logic [6:0] gap_pat;
    logic [W-1:0] sat_exp;
    int wi;

    initial begin
        vecs[0] = mk(5, 7, 9, 11, 0, 1, 2, 3, 5, 7, 9, 11);
        vecs[1] = mk(3, 4, 5, 6, 2, 2, 2, 2, 0, 0, 18, 0);
        vecs[2] = mk(1, 2, 3, 4, 3, 3, 3, 3, 0, 0, 0, 10);
        vecs[3] = mk(100, 200, 300, 400, 1, 1, 0, 0, 700, 300, 0, 0);

        @(negedge clk);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_in_ready", 32'(in_ready4), 32'd0);
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_ovf", 32'(ovf4), 32'd0);
        check("rst_out_data", 32'(out_data4), 32'd0);
        check("rst_out_idx", 32'(out_idx4), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("idle_wait_busy", 32'(busy4), 32'd0);

        // Table-driven NACC=4 runs.
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            start4_pulse();
            check("accum_busy", 32'(busy4), 32'd1);
            check("accum_in_ready", 32'(in_ready4), 32'd1);
            for (int k = 0; k < 4; k++) begin
                check("accum_no_valid", 32'(out_valid4), 32'd0);
                feed4(v.d[k], v.s[k]);
            end
            check("in_ready_drain", 32'(in_ready4), 32'd0);
            drain4(v.e, 0);
            check("ovf_clear", 32'(ovf4), 32'd0);
        end

        // in_valid while idle is not accepted.
        in_valid4 = 1; in_data4 = W'(99); in_sel4 = 0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready4), 32'd0);
        check("idle_busy", 32'(busy4), 32'd0);
        in_valid4 = 0;

        // Output stall with a stray start pulse.
        v = vecs[0];
        start4_pulse();
        for (int k = 0; k < 4; k++) feed4(v.d[k], v.s[k]);
        out_ready4 = 1;
        @(negedge clk);
        out_ready4 = 0;
        for (int c = 0; c < 5; c++) begin
            start4 = (c == 2);
            check("stall_valid", 32'(out_valid4), 32'd1);
            check("stall_idx", 32'(out_idx4), 32'd1);
            check("stall_data", 32'(out_data4), 32'd7);
            @(negedge clk);
        end
        start4 = 0;
        drain4(v.e, 1);
        check("stall_no_restart", 32'(busy4), 32'd0);

        // Asynchronous reset mid-accumulation.
        start4_pulse();
        feed4(W'(5), 2'd0);
        feed4(W'(7), 2'd1);
        #2;
        rst_n = 0;
        #1;
        check("arst_busy", 32'(busy4), 32'd0);
        check("arst_in_ready", 32'(in_ready4), 32'd0);
        check("arst_out_valid", 32'(out_valid4), 32'd0);
        check("arst_ovf", 32'(ovf4), 32'd0);
        check("arst_out_data", 32'(out_data4), 32'd0);
        check("arst_out_idx", 32'(out_idx4), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("arst_idle", 32'(busy4), 32'd0);
        v = mk(1, 1, 1, 1, 0, 0, 1, 1, 2, 2, 0, 0);
        start4_pulse();
        for (int k = 0; k < 4; k++) feed4(v.d[k], v.s[k]);
        drain4(v.e, 0);

        // in_valid gaps: 1,0,0,1,1,0,1 (LSB first).
        gap_pat = 7'b1011001;
        wi = 1;
        start4_pulse();
        for (int c = 0; c < 7; c++) begin
            in_valid4 = gap_pat[c];
            in_data4  = W'(wi);
            in_sel4   = 2'd0;
            check("gap_in_ready", 32'(in_ready4), 32'd1);
            @(negedge clk);
            if (gap_pat[c]) wi++;
        end
        in_valid4 = 0;
        check("gap_drain_now", 32'(out_valid4), 32'd1);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0);
        drain4(v.e, 0);

        // Overflow with NACC=2.
`ifdef AC3_SAT_EN
        sat_exp = W'(32'h1FFF_FFFF);
`else
        sat_exp = W'(32'h0000_0010);
`endif
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        in_valid2 = 1; in_sel2 = 0; in_data2 = W'(32'h1FFF_FFF0);
        @(negedge clk);
        in_data2 = W'(32'h20);
        check("ovf_before", 32'(ovf2), 32'd0);
        @(negedge clk);
        in_valid2 = 0;
        check("ovf_set", 32'(ovf2), 32'd1);
        check("ovf_drain_valid", 32'(out_valid2), 32'd1);
        check("ovf_acc0", 32'(out_data2), 32'(sat_exp));
        out_ready2 = 1;
        repeat (4) @(negedge clk);
        out_ready2 = 0;
        check("ovf_idle", 32'(busy2), 32'd0);
        check("ovf_sticky", 32'(ovf2), 32'd1);
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        check("ovf_cleared_on_start", 32'(ovf2), 32'd0);

        // NACC=1: one word then drain.
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        in_valid1 = 1; in_sel1 = 2'd1; in_data1 = W'(9);
        @(negedge clk);
        in_valid1 = 0;
        out_ready1 = 1;
        for (int k = 0; k < 4; k++) begin
            check("n1_valid", 32'(out_valid1), 32'd1);
            check("n1_idx", 32'(out_idx1), 32'(k));
            check("n1_data", 32'(out_data1), (k == 1) ? 32'd9 : 32'd0);
            @(negedge clk);
        end
        out_ready1 = 0;
        check("n1_idle", 32'(busy1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
